s2p: RTL

S2P -- requirements
Module: s2p

---
 rtl/s2p.sv | 49 ++++
 1 files changed

// File: rtl/s2p.sv
// s2p: LSB-first serial-to-parallel converter with a one-word skid buffer (sr) behind the output register.
module s2p #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready
);
  localparam int CW = $clog2(N);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t       state, state_n;
  logic [N-1:0] sr, sr_n, p_data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic         p_valid_n, take, last, free, load;
  assign s_ready = rstn && state == COLLECT;
  always_comb begin
    take = s_valid && s_ready;
    last = cnt == CW'(N - 1);
    free = !p_valid || p_ready;
    sr_n = sr;
    if (take) sr_n[cnt] = s_data;
    cnt_n = take ? (last ? '0 : cnt + 1'b1) : cnt;
    // In HOLD sr_n equals sr, so one load path serves both the direct and the held word
    load = ((take && last) || state == HOLD) && free;
    state_n = (take && last && !free) ? HOLD : (state == HOLD && free) ? COLLECT : state;
    p_data_n = load ? sr_n : p_data;
    p_valid_n = load ? 1'b1 : (p_ready ? 1'b0 : p_valid);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= COLLECT;
      sr <= '0;
      cnt <= '0;
      p_data <= '0;
      p_valid <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      p_data <= p_data_n;
      p_valid <= p_valid_n;
    end
  end
endmodule
